seq_stage_sequencer: RTL and testbench
======================================

// Module: seq_stage_sequencer
// PURPOSE
//  Control FSM for the Y86-64 SEQ processor. Steps one instruction at a time through
//  fetch, decode, execute, memory, writeback and PC update, one stage-enable per state.
//  Stalls the memory stage on a data-memory req/ready handshake.
//  Sets the architectural status code (stat) and stops on halt or on any error.
// PARAMETERS
//  MEM_TIMEOUT  15  max cycles mem_req may wait for mem_ready before stat=ADR (1..255)
//  CNT_W        32  width of the retired-instruction counter
// PORTS
//  clk           in   1      system clock; all state changes on posedge
//  reset         in   1      synchronous, active-high reset
//  start         in   1      pulse; leaves IDLE and begins fetching
//  icode         in   4      instruction code from fetch; sampled in last FETCH cycle
//  instr_valid   in   1      fetch decoded a legal icode/ifun
//  imem_error    in   1      fetch address out of range
//  mem_ready     in   1      data memory completed the access
//  dmem_error    in   1      data memory address error; qualified by mem_ready
//  fetch_en      out  1      high while state==FETCH
//  decode_en     out  1      high while state==DECODE
//  execute_en    out  1      high while state==EXECUTE
//  cc_en         out  1      high in EXECUTE when icode_q==4'h6 (OPq)
//  memory_en     out  1      high while state==MEMORY
//  mem_req       out  1      high in MEMORY for icode_q in {4,5,8,9,A,B} until mem_ready
//  writeback_en  out  1      high while state==WRITEBACK
//  pcupdate_en   out  1      high while state==PCUPDATE
//  busy          out  1      high in every state except IDLE and HALTED
//  stat          out  3      1=AOK 2=HLT 3=ADR 4=INS
//  instr_count   out  CNT_W  instructions retired (PCUPDATE exits)
// BEHAVIOUR
//  - Reset (any state, mid-instruction included): state=IDLE, all enables/mem_req/busy=0,
//    stat=1, instr_count=0, icode_q=0, timeout counter=0.
//  - States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPDATE, HALTED.
//  - Each state lasts 1 cycle; MEMORY may last longer (see below).
//  - Enables are decoded from the state register: no extra latency, mutually exclusive.
//  - IDLE: start=1 -> FETCH. start in any other state is ignored.
//  - FETCH exit, priority order; icode_q<=icode:
//    - imem_error -> stat=3, HALTED.
//    - else !instr_valid -> stat=4, HALTED.
//    - else icode==0 (halt) -> stat=2, HALTED; instr_count not incremented.
//    - else -> DECODE.
//  - DECODE -> EXECUTE -> MEMORY.
//  - MEMORY, non-memory icode: 1 cycle, mem_req=0 -> WRITEBACK.
//  - MEMORY, memory icode: mem_req=1 from entry and held until the cycle mem_ready=1
//    (including that cycle).
//    - mem_ready && dmem_error -> stat=3, HALTED.
//    - mem_ready && !dmem_error -> WRITEBACK.
//    - mem_ready already high on the entry cycle: exactly 1 MEMORY cycle.
//    - After MEM_TIMEOUT cycles without mem_ready -> stat=3, HALTED.
//      Timeout counter clears on entering MEMORY.
//  - WRITEBACK -> PCUPDATE.
//  - PCUPDATE: instr_count+=1 (saturates at all-ones) -> FETCH.
//  - HALTED: all enables 0, busy=0, stat held; left only by reset.
//  - Base latency: 6 cycles per instruction plus memory wait cycles.
// CONFIGURATION
//  SEQ_SKIP_IDLE_STAGES_EN
//   defined:
//    - icode 1 (nop): FETCH -> PCUPDATE.
//    - MEMORY skipped (EXECUTE -> WRITEBACK) for icode not in {4,5,8,9,A,B}.
//    - WRITEBACK skipped (MEMORY/EXECUTE -> PCUPDATE) for icode 4 (rmmovq) and 7 (jXX).
//   undefined: every instruction visits all six stages; behaviour exactly as above.
// TESTING
//  - reset; start; icode=6 valid -> FETCH..PCUPDATE in 6 cycles; cc_en 1 cycle only;
//    instr_count=1, stat=1.
//  - icode=5; mem_ready rises 3 cycles after MEMORY entry -> mem_req high 4 cycles;
//    WRITEBACK next; instr_count increments.
//  - icode=A; mem_ready never rises -> after 15 MEMORY cycles stat=3, HALTED, busy=0.
//  - icode=0 -> stat=2, HALTED; instr_count unchanged; later start ignored.
//  - instr_valid=0 with imem_error=1 -> stat=3 (error priority); imem_error=0 -> stat=4.
//  - reset asserted during MEMORY wait -> next cycle IDLE, outputs at reset values.
//  - SEQ_SKIP_IDLE_STAGES_EN defined, icode=1 -> FETCH then PCUPDATE (2 cycles);
//    icode=6 -> 5 cycles.

Source files
------------

// File: rtl/seq_stage_sequencer_if.sv
// rtl/seq_stage_sequencer_if.sv - handshake and stage-enable bundle of the SEQ sequencer
interface seq_stage_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [3:0]       icode;
  logic             instr_valid;
  logic             imem_error;
  logic             mem_ready;
  logic             dmem_error;
  logic             fetch_en;
  logic             decode_en;
  logic             execute_en;
  logic             cc_en;
  logic             memory_en;
  logic             mem_req;
  logic             writeback_en;
  logic             pcupdate_en;
  logic             busy;
  logic [2:0]       stat;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output start, icode, instr_valid, imem_error, mem_ready, dmem_error,
    input  fetch_en, decode_en, execute_en, cc_en, memory_en, mem_req,
           writeback_en, pcupdate_en, busy, stat, instr_count
  );

  modport slave (
    input  start, icode, instr_valid, imem_error, mem_ready, dmem_error,
    output fetch_en, decode_en, execute_en, cc_en, memory_en, mem_req,
           writeback_en, pcupdate_en, busy, stat, instr_count
  );
endinterface

// File: rtl/seq_stage_sequencer.sv
// rtl/seq_stage_sequencer.sv - Y86-64 SEQ stage-enable FSM with data-memory stall and status
// Optional SEQ_SKIP_IDLE_STAGES_EN: bypass stages an instruction does not use.
module seq_stage_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input logic             clk,
  input logic             reset,
  seq_stage_sequencer_if.slave bus
);

`ifdef SEQ_SKIP_IDLE_STAGES_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPDATE, S_HALTED
  } state_t;

  state_t           state;
  logic [3:0]       icode_q;
  logic [7:0]       tmo_cnt;
  logic [2:0]       stat_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic is_mem(input logic [3:0] code);
    return code inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  endfunction

  // rmmovq and jXX have nothing to write back to the register file
  function automatic logic wb_skipped(input logic [3:0] code);
    return SKIP && (code == 4'h4 || code == 4'h7);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      icode_q <= 4'h0;
      tmo_cnt <= 8'd0;
      stat_q  <= STAT_AOK;
      count_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) state <= S_FETCH;
        S_FETCH: begin
          icode_q <= bus.icode;
          if (bus.imem_error) begin
            stat_q <= STAT_ADR;
            state  <= S_HALTED;
          end else if (!bus.instr_valid) begin
            stat_q <= STAT_INS;
            state  <= S_HALTED;
          end else if (bus.icode == 4'h0) begin
            stat_q <= STAT_HLT;
            state  <= S_HALTED;
          end else if (SKIP && bus.icode == 4'h1) begin
            state <= S_PCUPDATE;
          end else begin
            state <= S_DECODE;
          end
        end
        S_DECODE: state <= S_EXECUTE;
        S_EXECUTE: begin
          tmo_cnt <= 8'd0;
          if (!SKIP || is_mem(icode_q))  state <= S_MEMORY;
          else if (wb_skipped(icode_q))  state <= S_PCUPDATE;
          else                           state <= S_WRITEBACK;
        end
        S_MEMORY: begin
          if (!is_mem(icode_q)) begin
            state <= S_WRITEBACK;
          end else if (bus.mem_ready) begin
            if (bus.dmem_error) begin
              stat_q <= STAT_ADR;
              state  <= S_HALTED;
            end else begin
              state <= wb_skipped(icode_q) ? S_PCUPDATE : S_WRITEBACK;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            stat_q <= STAT_ADR;
            state  <= S_HALTED;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_WRITEBACK: state <= S_PCUPDATE;
        S_PCUPDATE: begin
          if (count_q != '1) count_q <= count_q + CNT_W'(1);
          state <= S_FETCH;
        end
        S_HALTED: state <= S_HALTED;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign bus.fetch_en     = (state == S_FETCH);
  assign bus.decode_en    = (state == S_DECODE);
  assign bus.execute_en   = (state == S_EXECUTE);
  assign bus.cc_en        = (state == S_EXECUTE) && (icode_q == 4'h6);
  assign bus.memory_en    = (state == S_MEMORY);
  assign bus.mem_req      = (state == S_MEMORY) && is_mem(icode_q);
  assign bus.writeback_en = (state == S_WRITEBACK);
  assign bus.pcupdate_en  = (state == S_PCUPDATE);
  assign bus.busy         = (state != S_IDLE) && (state != S_HALTED);
  assign bus.stat         = stat_q;
  assign bus.instr_count  = count_q;

endmodule

// File: tb/tb_seq_stage_sequencer.sv
// tb/tb_seq_stage_sequencer.sv - randomized bench for seq_stage_sequencer against a per-instruction stage model
module tb_seq_stage_sequencer;

`ifdef SEQ_SKIP_IDLE_STAGES_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam int MEM_TIMEOUT = 15;
  localparam int NOP_CYC = SKIP ? 2 : 6;
  localparam int OPQ_CYC = SKIP ? 5 : 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_stage_sequencer_if #(.CNT_W(32)) bus ();

  seq_stage_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [8:0]  en;
    logic [2:0]  stat;
    logic [31:0] cnt;
  } exp_t;

  exp_t        expq[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cc_cnt = 0, mreq_cnt = 0, busy_cnt = 0;
  logic [2:0]  m_stat = 3'd1;
  logic [31:0] m_count = 32'd0;
  bit          m_halted = 1'b0;

  // stage codes: 0 idle, 1..6 fetch..pcupdate, 7 halted
  function automatic exp_t mk(input int stg, input bit cc, input bit mreq);
    exp_t e;
    e.en   = {stg == 1, stg == 2, stg == 3, cc, stg == 4, mreq, stg == 5, stg == 6,
              (stg >= 1 && stg <= 6)};
    e.stat = m_stat;
    e.cnt  = m_count;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e, a;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a.en   = {bus.fetch_en, bus.decode_en, bus.execute_en, bus.cc_en, bus.memory_en,
                bus.mem_req, bus.writeback_en, bus.pcupdate_en, bus.busy};
      a.stat = bus.stat;
      a.cnt  = bus.instr_count;
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle_check t=%0t act en=%b stat=%0d cnt=%0d req en=%b stat=%0d cnt=%0d",
                 $time, a.en, a.stat, a.cnt, e.en, e.stat, e.cnt);
      end
      cc_cnt   += int'(bus.cc_en);
      mreq_cnt += int'(bus.mem_req);
      busy_cnt += int'(bus.busy);
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s act=%0d req=%0d", name, act, req);
    end
  endtask

  task automatic step(input exp_t e);
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    bus.start       = 1'($urandom);
    bus.icode       = 4'($urandom);
    bus.instr_valid = 1'($urandom);
    bus.imem_error  = 1'($urandom);
    bus.mem_ready   = 1'($urandom);
    bus.dmem_error  = 1'($urandom);
  endtask

  task automatic clear_counts();
    cc_cnt = 0; mreq_cnt = 0; busy_cnt = 0;
  endtask

  task automatic do_reset();
    noise();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    m_stat   = 3'd1;
    m_count  = 32'd0;
    m_halted = 1'b0;
  endtask

  task automatic do_start();
    noise();
    bus.start = 1'b1;
    step(mk(0, 0, 0));
  endtask

  task automatic halt_with(input logic [2:0] s);
    m_stat   = s;
    m_halted = 1'b1;
  endtask

  // Walks one instruction through the stages it must visit, driving and predicting each cycle.
  task automatic run_instr(input logic [3:0] ic, input bit valid, input bit ierr,
                           input int rdly, input bit derr, input int rst_at);
    bit is_mem;
    is_mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    noise();
    bus.icode = ic; bus.instr_valid = valid; bus.imem_error = ierr;
    step(mk(1, 0, 0));
    if (ierr)        begin halt_with(3'd3); return; end
    if (!valid)      begin halt_with(3'd4); return; end
    if (ic == 4'h0)  begin halt_with(3'd2); return; end
    if (!(SKIP && ic == 4'h1)) begin
      noise(); step(mk(2, 0, 0));
      noise(); step(mk(3, ic == 4'h6, 0));
      if (!SKIP || is_mem) begin
        if (is_mem) begin
          for (int k = 0; k < MEM_TIMEOUT; k++) begin
            noise();
            bus.mem_ready = (k == rdly);
            if (k == rdly) bus.dmem_error = derr;
            if (k == rst_at) begin reset = 1'b1; bus.mem_ready = 1'b0; end
            step(mk(4, 0, 1));
            if (k == rst_at) begin
              reset = 1'b0; m_stat = 3'd1; m_count = 32'd0; m_halted = 1'b0;
              return;
            end
            if (k == rdly) begin
              if (derr) begin halt_with(3'd3); return; end
              break;
            end
            if (k == MEM_TIMEOUT - 1) begin halt_with(3'd3); return; end
          end
        end else begin
          noise(); step(mk(4, 0, 0));
        end
      end
      if (!(SKIP && (ic == 4'h4 || ic == 4'h7))) begin
        noise(); step(mk(5, 0, 0));
      end
    end
    noise(); step(mk(6, 0, 0));
    if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
  endtask

  initial begin
    logic [3:0] ic;
    bit         v;
    noise();
    do_reset();
    check("reset_stat", bus.stat, 1);
    check("reset_count", bus.instr_count, 0);
    check("reset_busy", bus.busy, 0);
    bus.start = 1'b0;
    step(mk(0, 0, 0));

    do_start();
    clear_counts();
    run_instr(4'h6, 1, 0, 0, 0, -1);
    check("opq_cc_cycles", cc_cnt, 1);
    check("opq_cycles", busy_cnt, OPQ_CYC);
    check("opq_count", bus.instr_count, 1);
    check("opq_stat", bus.stat, 1);

    clear_counts();
    run_instr(4'h5, 1, 0, 3, 0, -1);
    check("mrmovq_req_cycles", mreq_cnt, 4);
    check("mrmovq_count", bus.instr_count, 2);

    clear_counts();
    run_instr(4'hA, 1, 0, 1000, 0, -1);
    check("timeout_req_cycles", mreq_cnt, 15);
    check("timeout_stat", bus.stat, 3);
    check("timeout_busy", bus.busy, 0);

    do_reset(); do_start();
    run_instr(4'h0, 1, 0, 0, 0, -1);
    repeat (3) begin noise(); bus.start = 1'b1; step(mk(7, 0, 0)); end
    check("halt_stat", bus.stat, 2);
    check("halt_count", bus.instr_count, 0);
    check("halt_busy_after_start", bus.busy, 0);

    do_reset(); do_start();
    run_instr(4'h3, 0, 1, 0, 0, -1);
    check("imem_err_stat", bus.stat, 3);
    do_reset(); do_start();
    run_instr(4'h3, 0, 0, 0, 0, -1);
    check("ins_stat", bus.stat, 4);

    do_reset(); do_start();
    run_instr(4'h8, 1, 0, 1000, 0, 2);
    check("midmem_reset_busy", bus.busy, 0);
    check("midmem_reset_stat", bus.stat, 1);
    check("midmem_reset_req", bus.mem_req, 0);
    noise(); bus.start = 1'b0;
    step(mk(0, 0, 0));

    do_start();
    clear_counts();
    run_instr(4'h1, 1, 0, 0, 0, -1);
    check("nop_cycles", busy_cnt, NOP_CYC);
    clear_counts();
    run_instr(4'h7, 1, 0, 0, 0, -1);
    check("jxx_cycles", busy_cnt, SKIP ? 4 : 6);
    check("nop_jxx_count", bus.instr_count, 2);

    for (int i = 0; i < 200; i++) begin
      if (m_halted) begin
        repeat (2) begin noise(); step(mk(7, 0, 0)); end
        do_reset(); do_start();
      end
      ic = 4'($urandom_range(0, 15));
      if (ic == 4'h0 && $urandom_range(0, 2) != 0) ic = 4'h6;
      v  = (ic <= 4'hB) && ($urandom_range(0, 15) != 0);
      run_instr(ic, v, $urandom_range(0, 19) == 0, $urandom_range(0, 18),
                $urandom_range(0, 7) == 0, -1);
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
